hpm_counter_bank: RTL and testbench
===================================

Name: hpm_counter_bank

Overview:
- Synthesizable, parametrised bank of hardware performance counters for the pipelined core.
- Counts per-cycle events such as I-cache and D-cache stall cycles, hits and misses, flushes, branches, and predictor-correct branches.
- Provides atomic snapshot, per-channel random read, and a sequential dump stream, so the same statistics are available in silicon and in simulation.
- Sits beside the datapath; event lines come from the datapath and cache controllers.

Parameters:
- NUM_CH, 8, number of counter channels (>=2).
- CNT_W, 32, width of each counter in bits (8..64).
- INC_W, 2, width of each per-channel increment (0..2^INC_W-1 per cycle, for multi-event cycles).
- SATURATE, 0, 0 = counters wrap modulo 2^CNT_W; 1 = counters hold at all-ones.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- event_inc  in  NUM_CH*INC_W  per-channel increment; channel i occupies bits [i*INC_W +: INC_W].
- stall  in  1  pipeline stall (I-cache stall OR D-cache stall).
- gate_mask  in  NUM_CH  1 = channel i does not count while stall=1.
- enable  in  1  global count enable.
- clear  in  1  zero all live counters and overflow flags.
- snap_req  in  1  copy all live counters into shadow registers.
- rd_req  in  1  random read of shadow[rd_sel].
- rd_sel  in  $clog2(NUM_CH)  channel index for rd_req.
- dump_req  in  1  stream all shadows, channel 0 first.
- rd_valid  out  1  rd_data valid this cycle.
- rd_last  out  1  final beat of a dump; also asserted on a random-read response.
- rd_ch  out  $clog2(NUM_CH)  channel index of rd_data.
- rd_data  out  CNT_W  shadow counter value.
- busy  out  1  dump in progress.
- overflow  out  NUM_CH  sticky per-channel overflow flag.

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - While rst=1 at a posedge, all live counters, shadows, overflow, rd_valid, rd_last, rd_ch, rd_data and busy go to 0, and the FSM goes to IDLE.
  - rst mid-dump aborts the dump with no further beats.
- Count rule: channel i adds inc_i = event_inc[i] when enable=1 AND NOT (stall AND gate_mask[i]). Otherwise it holds.
- Arithmetic: sum is computed at CNT_W+1 bits.
  - SATURATE=0: counter <= sum[CNT_W-1:0]; overflow[i] <= 1 when sum[CNT_W]=1.
  - SATURATE=1: if sum[CNT_W]=1, counter <= all-ones and overflow[i] <= 1. Already-saturated counters stay at all-ones.
- overflow is sticky; only clear or rst resets it.
- clear priority:
  - clear overrides the increment: counters become 0 next cycle, and that cycle's events are lost.
  - clear does not touch shadows.
- Snapshot:
  - On a snap_req cycle, shadow[i] <= live counter value before that cycle's update or clear.
  - snap_req and clear in the same cycle: shadows get the pre-clear values.
  - snap_req while busy=1 is ignored, so a dump is always self-consistent.
- FSM states are IDLE and DUMP.
- IDLE:
  - dump_req=1 -> enter DUMP, idx=0, busy=1 next cycle.
  - Else rd_req=1 -> one-cycle latency: next cycle rd_valid=1, rd_last=1, rd_ch=rd_sel, rd_data=shadow[rd_sel].
  - rd_sel >= NUM_CH returns rd_data=0 with rd_valid=1.
  - dump_req and rd_req in the same cycle: dump wins and rd_req is dropped.
  - rd_req in the same cycle as snap_req returns the old shadow value.
- DUMP:
  - Each cycle: rd_valid=1, rd_ch=idx, rd_data=shadow[idx], then idx++.
  - On idx=NUM_CH-1, rd_last=1, and the next state is IDLE with busy=0.
  - A dump is exactly NUM_CH consecutive beats, with no back-pressure.
  - rd_req and dump_req are ignored while in DUMP.
- Outputs are registered. rd_valid and rd_last are low whenever no beat is presented. rd_data and rd_ch hold their last value when rd_valid=0.
- Counting continues unaffected during reads and dumps.

Test Plan:
- Basic count and read: NUM_CH=4, INC_W=2, enable=1.
  - Drive ch0=1 and ch1=3 for 10 cycles, then snap_req, then rd_req with rd_sel=1.
  - Required: one cycle later rd_valid=1, rd_ch=1, rd_data=30, rd_last=1. Reading ch0 gives 10.
- Stall gating: gate_mask=4'b0010, stall=1 for 5 of 10 cycles, ch0 and ch1 each +1 per cycle.
  - Required: snapshot shows ch0=10, ch1=5.
- Wrap versus saturate: CNT_W=8, preload via 254 single increments, then apply inc=3.
  - SATURATE=0: counter=1, overflow[0]=1.
  - SATURATE=1: counter=255, overflow[0]=1.
  - A following clear zeroes both the counter and overflow.
- Snapshot and clear in the same cycle with live ch2=77:
  - Next cycle the live count is 0 and shadow[2]=77.
  - The event on the clear cycle is not counted.
- Dump: NUM_CH=4, shadows holding 5, 6, 7, 8, assert dump_req.
  - Required: 4 consecutive beats rd_ch=0..3 with data 5, 6, 7, 8, and rd_last only on beat 3.
  - busy is high for exactly 4 cycles; a snap_req and an rd_req issued mid-dump are ignored.
- Reset mid-dump: rst asserted on beat 1.
  - Required: next cycle busy=0, rd_valid=0, and all counters, shadows and overflow flags are 0.

Source files
------------

// File: rtl/hpm_counter_bank.sv
// Bank of hardware performance counters with a shadow snapshot, a random-read port
// and a sequential dump stream. All channels share one shadow/read datapath.
module hpm_cnt_lane #(
  parameter int CNT_W    = 32,
  parameter int INC_W    = 2,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [INC_W-1:0] i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_ovf
);
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [CNT_W:0]   w_sum;

  // One spare bit catches the carry out of the counter.
  assign w_sum = {1'b0, r_cnt} + {{(CNT_W+1-INC_W){1'b0}}, i_inc};

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (i_en) begin
      if (w_sum[CNT_W]) begin
        r_ovf <= 1'b1;
        r_cnt <= (SATURATE != 0) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
      end else begin
        r_cnt <= w_sum[CNT_W-1:0];
      end
    end
  end

  assign o_cnt = r_cnt;
  assign o_ovf = r_ovf;
endmodule

module hpm_counter_bank #(
  parameter int NUM_CH   = 8,
  parameter int CNT_W    = 32,
  parameter int INC_W    = 2,
  parameter int SATURATE = 0,
  localparam int IDX_W   = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*INC_W-1:0] event_inc,
  input  logic                    stall,
  input  logic [NUM_CH-1:0]       gate_mask,
  input  logic                    enable,
  input  logic                    clear,
  input  logic                    snap_req,
  input  logic                    rd_req,
  input  logic [IDX_W-1:0]        rd_sel,
  input  logic                    dump_req,
  output logic                    rd_valid,
  output logic                    rd_last,
  output logic [IDX_W-1:0]        rd_ch,
  output logic [CNT_W-1:0]        rd_data,
  output logic                    busy,
  output logic [NUM_CH-1:0]       overflow
);
  typedef enum logic {S_IDLE, S_DUMP} state_t;

  state_t                         r_state;
  logic [IDX_W-1:0]               r_idx;
  logic                           r_busy, r_valid, r_last;
  logic [IDX_W-1:0]               r_ch;
  logic [CNT_W-1:0]               r_data;
  logic [NUM_CH-1:0][CNT_W-1:0]   r_shadow;
  logic [NUM_CH-1:0][CNT_W-1:0]   w_cnt;
  logic [NUM_CH-1:0]              w_ovf;
  logic [IDX_W-1:0]               w_sel;
  logic [CNT_W-1:0]               w_sel_data;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    hpm_cnt_lane #(.CNT_W(CNT_W), .INC_W(INC_W), .SATURATE(SATURATE)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .i_en  (enable && !(stall && gate_mask[g])),
      .i_clr (clear),
      .i_inc (event_inc[g*INC_W +: INC_W]),
      .o_cnt (w_cnt[g]),
      .o_ovf (w_ovf[g])
    );
  end

  // Snapshots are frozen while a dump streams them out.
  always_ff @(posedge clk) begin
    if (rst)
      r_shadow <= '0;
    else if (snap_req && r_state != S_DUMP)
      r_shadow <= w_cnt;
  end

  // Shared shadow mux; out-of-range selects read as zero.
  always_comb begin
    w_sel      = (r_state == S_DUMP) ? r_idx : rd_sel;
    w_sel_data = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (w_sel == IDX_W'(i)) w_sel_data = r_shadow[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_ch    <= '0;
      r_data  <= '0;
    end else begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (dump_req) begin
            r_state <= S_DUMP;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end else if (rd_req) begin
            r_valid <= 1'b1;
            r_last  <= 1'b1;
            r_ch    <= rd_sel;
            r_data  <= w_sel_data;
          end
        end
        S_DUMP: begin
          r_valid <= 1'b1;
          r_ch    <= r_idx;
          r_data  <= w_sel_data;
          if (r_idx == IDX_W'(NUM_CH-1)) begin
            r_last  <= 1'b1;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_valid = r_valid;
  assign rd_last  = r_last;
  assign rd_ch    = r_ch;
  assign rd_data  = r_data;
  assign busy     = r_busy;
  assign overflow = w_ovf;
endmodule

// File: tb/tb_hpm_counter_bank.sv
// Scoreboarded bench: a wrap-mode and a saturate-mode bank share stimulus; an
// arithmetic reference model predicts every read beat, busy and overflow.
module tb_hpm_counter_bank;
  localparam int N  = 4;
  localparam int CW = 8;
  localparam int IW = 2;
  localparam int MAXV = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N*IW-1:0] event_inc = '0;
  logic stall = 1'b0, enable = 1'b0, clear = 1'b0;
  logic snap_req = 1'b0, rd_req = 1'b0, dump_req = 1'b0;
  logic [N-1:0] gate_mask = '0;
  logic [1:0] rd_sel = '0;

  logic w_rd_valid, w_rd_last, w_busy, s_rd_valid, s_rd_last, s_busy;
  logic [1:0] w_rd_ch, s_rd_ch;
  logic [CW-1:0] w_rd_data, s_rd_data;
  logic [N-1:0] w_ovf, s_ovf;

  always #5 clk = ~clk;

  hpm_counter_bank #(.NUM_CH(N), .CNT_W(CW), .INC_W(IW), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .event_inc(event_inc), .stall(stall), .gate_mask(gate_mask),
    .enable(enable), .clear(clear), .snap_req(snap_req), .rd_req(rd_req), .rd_sel(rd_sel),
    .dump_req(dump_req), .rd_valid(w_rd_valid), .rd_last(w_rd_last), .rd_ch(w_rd_ch),
    .rd_data(w_rd_data), .busy(w_busy), .overflow(w_ovf));

  hpm_counter_bank #(.NUM_CH(N), .CNT_W(CW), .INC_W(IW), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .event_inc(event_inc), .stall(stall), .gate_mask(gate_mask),
    .enable(enable), .clear(clear), .snap_req(snap_req), .rd_req(rd_req), .rd_sel(rd_sel),
    .dump_req(dump_req), .rd_valid(s_rd_valid), .rd_last(s_rd_last), .rd_ch(s_rd_ch),
    .rd_data(s_rd_data), .busy(s_busy), .overflow(s_ovf));

  typedef struct { int cyc; int ch; int dw; int ds; bit last; } exp_t;
  exp_t q[$];
  exp_t me;

  int n_err = 0, n_chk = 0, cyc = 0;
  bit mon_on = 1'b0;
  int live [2][N];
  int shd  [2][N];
  bit movf [2][N];
  bit m_busy = 1'b0;
  int m_idx = 0;
  bit exp_busy = 1'b0, exp_busy_nxt = 1'b0;
  logic [N-1:0] exp_ovf [2];
  logic [N-1:0] exp_ovf_nxt [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: what the counters, shadows and read port must do this cycle.
  task automatic model_step();
    exp_t e;
    bit was_busy;
    int inc, sum;
    e.cyc = cyc + 1;
    if (rst) begin
      for (int s = 0; s < 2; s++)
        for (int c = 0; c < N; c++) begin live[s][c] = 0; shd[s][c] = 0; movf[s][c] = 0; end
      m_busy = 0; m_idx = 0;
    end else begin
      was_busy = m_busy;
      if (m_busy) begin
        e.ch = m_idx; e.dw = shd[0][m_idx]; e.ds = shd[1][m_idx]; e.last = (m_idx == N-1);
        q.push_back(e);
        if (e.last) m_busy = 0; else m_idx++;
      end else if (dump_req) begin
        m_busy = 1; m_idx = 0;
      end else if (rd_req) begin
        e.ch = rd_sel; e.dw = shd[0][rd_sel]; e.ds = shd[1][rd_sel]; e.last = 1;
        q.push_back(e);
      end
      if (snap_req && !was_busy)
        for (int s = 0; s < 2; s++)
          for (int c = 0; c < N; c++) shd[s][c] = live[s][c];
      for (int s = 0; s < 2; s++)
        for (int c = 0; c < N; c++) begin
          inc = (event_inc >> (c*IW)) & ((1 << IW) - 1);
          if (clear) begin
            live[s][c] = 0; movf[s][c] = 0;
          end else if (enable && !(stall && gate_mask[c])) begin
            sum = live[s][c] + inc;
            if (sum > MAXV) begin
              movf[s][c] = 1;
              live[s][c] = (s == 1) ? MAXV : sum - (MAXV + 1);
            end else live[s][c] = sum;
          end
        end
    end
    exp_busy_nxt = m_busy;
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < N; c++) exp_ovf_nxt[s][c] = movf[s][c];
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    exp_busy = exp_busy_nxt;
    exp_ovf  = exp_ovf_nxt;
    #1;
    rst = 0; snap_req = 0; rd_req = 0; dump_req = 0; clear = 0;
  endtask

  task automatic read_ch(input int ch, input int ew, input int es, input string name);
    rd_sel = 2'(ch); rd_req = 1; tick();
    chk({name, "_valid"}, w_rd_valid, 1);
    chk({name, "_ch"}, w_rd_ch, ch);
    chk({name, "_wrap"}, w_rd_data, ew);
    chk({name, "_sat"}, s_rd_data, es);
  endtask

  always @(negedge clk) if (mon_on) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      me = q.pop_front();
      chk("missing_beat", 0, 1);
    end
    if (w_rd_valid) begin
      if (q.size() == 0) chk("unexpected_beat", 1, 0);
      else begin
        me = q.pop_front();
        chk("beat_cycle", cyc, me.cyc);
        chk("beat_ch", w_rd_ch, me.ch);
        chk("beat_wrap_data", w_rd_data, me.dw);
        chk("beat_sat_data", s_rd_data, me.ds);
        chk("beat_last", w_rd_last, me.last);
        chk("sat_valid", s_rd_valid, 1);
      end
    end else begin
      chk("idle_last", w_rd_last, 0);
      chk("sat_idle_valid", s_rd_valid, 0);
      if (q.size() > 0 && q[0].cyc == cyc) begin
        me = q.pop_front();
        chk("missing_beat", 0, 1);
      end
    end
    chk("busy_wrap", w_busy, exp_busy);
    chk("busy_sat", s_busy, exp_busy);
    chk("ovf_wrap", w_ovf, exp_ovf[0]);
    chk("ovf_sat", s_ovf, exp_ovf[1]);
  end

  initial begin
    int busy_cnt;
    // Reset state
    rst = 1; tick(); rst = 1; tick();
    mon_on = 1;
    chk("rst_busy", w_busy, 0);
    chk("rst_valid", w_rd_valid, 0);
    chk("rst_ovf", w_ovf, 0);
    chk("rst_data", w_rd_data, 0);
    chk("rst_ch", w_rd_ch, 0);

    // Basic count and read
    enable = 1; event_inc = 8'h0D;
    repeat (10) tick();
    event_inc = '0; snap_req = 1; tick();
    read_ch(1, 30, 30, "basic_ch1");
    chk("basic_last", w_rd_last, 1);
    read_ch(0, 10, 10, "basic_ch0");

    // Stall gating
    clear = 1; tick();
    gate_mask = 4'b0010; event_inc = 8'h05;
    for (int i = 0; i < 10; i++) begin stall = (i < 5); tick(); end
    stall = 0; gate_mask = '0; event_inc = '0; snap_req = 1; tick();
    read_ch(0, 10, 10, "gate_ch0");
    read_ch(1, 5, 5, "gate_ch1");

    // Wrap versus saturate
    clear = 1; tick();
    event_inc = 8'h01;
    repeat (254) tick();
    event_inc = 8'h03; tick();
    event_inc = '0; snap_req = 1; tick();
    read_ch(0, 1, 255, "ovf_cnt");
    chk("ovf_flag_wrap", w_ovf[0], 1);
    chk("ovf_flag_sat", s_ovf[0], 1);
    clear = 1; tick();
    chk("clr_ovf_wrap", w_ovf, 0);
    chk("clr_ovf_sat", s_ovf, 0);
    snap_req = 1; tick();
    read_ch(0, 0, 0, "clr_cnt");

    // Snapshot and clear together
    event_inc = 8'h10;
    repeat (77) tick();
    snap_req = 1; clear = 1; tick();
    event_inc = '0;
    read_ch(2, 77, 77, "snapclr_shadow");
    snap_req = 1; tick();
    read_ch(2, 0, 0, "snapclr_live");

    // Dump of shadows 5,6,7,8 with mid-dump snap/read ignored
    clear = 1; tick();
    event_inc = 8'h55; repeat (5) tick();
    event_inc = 8'h54; tick();
    event_inc = 8'h50; tick();
    event_inc = 8'h40; tick();
    event_inc = '0; snap_req = 1; tick();
    event_inc = 8'h01;
    dump_req = 1; tick();
    busy_cnt = int'(w_busy);
    chk("dump_start_valid", w_rd_valid, 0);
    for (int b = 0; b < N; b++) begin
      if (b == 1) begin snap_req = 1; rd_req = 1; rd_sel = 2'd3; end
      tick();
      busy_cnt += int'(w_busy);
      chk("dump_valid", w_rd_valid, 1);
      chk("dump_ch", w_rd_ch, b);
      chk("dump_data", w_rd_data, 5 + b);
      chk("dump_last", w_rd_last, (b == N-1));
    end
    chk("dump_busy_cycles", busy_cnt, N);
    event_inc = '0; tick();
    chk("dump_after_valid", w_rd_valid, 0);
    read_ch(0, 5, 5, "dump_snap_ignored");

    // Reset mid-dump
    event_inc = 8'hFF;
    dump_req = 1; tick();
    tick();
    rst = 1; tick();
    event_inc = '0;
    chk("rstdump_busy", w_busy, 0);
    chk("rstdump_valid", w_rd_valid, 0);
    chk("rstdump_ovf", w_ovf, 0);
    tick();
    chk("rstdump_no_beat", w_rd_valid, 0);
    for (int c = 0; c < N; c++) read_ch(c, 0, 0, "rstdump_shadow");
    snap_req = 1; tick();
    for (int c = 0; c < N; c++) read_ch(c, 0, 0, "rstdump_live");

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      event_inc = N*IW'($urandom);
      stall     = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) gate_mask = N'($urandom);
      enable    = ($urandom_range(0, 7) != 0);
      clear     = ($urandom_range(0, 39) == 0);
      snap_req  = ($urandom_range(0, 5) == 0);
      rd_req    = ($urandom_range(0, 2) == 0);
      rd_sel    = 2'($urandom);
      dump_req  = ($urandom_range(0, 11) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      tick();
    end
    event_inc = '0; enable = 0;
    repeat (N + 2) tick();
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
